// File: rtl/mips_unified_mem.sv
// mips_unified_mem
//   Word-addressed RAM at the far end of the mips core's instruction and data
//   buses, plus a host loader that fills it with a program image while the
//   core is held in reset. A sticky error flag catches stray core pointers.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   instr_addr / instr_in   fetch byte address / word, combinational read
//   data_addr, data_rd_wr   data byte address; 1 = read, 0 = write
//   data_out / data_in      store data in / registered load data out
//   ld_start                pulse: start (or restart) a load at word 0
//   ld_valid, ld_last       loader beat qualifier / final-beat marker
//   ld_data                 loader word
//   ld_ready                loader accepts a word this cycle
//   ld_done                 load complete, held until next ld_start or reset
//   err_addr                sticky out-of-range / misaligned access flag
module mips_unified_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_in,
  input  logic [31:0] data_addr,
  input  logic        data_rd_wr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic        ld_last,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        err_addr
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOADING,
    DONE
  } ld_state_t;

  ld_state_t     state;
  logic [AW-1:0] ld_ptr;
  logic          loaded_once;

  logic [31:0] mem [DEPTH_WORDS];

  // Address decode: offset wraps modulo 2^32, so addresses below the base
  // become huge offsets and fall out of range naturally.
  logic [31:0]   instr_off, data_off;
  logic          instr_in_range, data_in_range;
  logic [AW-1:0] instr_idx, data_idx;
  logic          instr_bad, data_bad;

  assign instr_off      = instr_addr - BASE_ADDR;
  assign data_off       = data_addr - BASE_ADDR;
  assign instr_in_range = instr_off < SPAN;
  assign data_in_range  = data_off < SPAN;
  assign instr_idx      = instr_off[AW+1:2];
  assign data_idx       = data_off[AW+1:2];
  assign instr_bad      = !instr_in_range || (instr_addr[1:0] != 2'b00);
  assign data_bad       = !data_in_range || (data_addr[1:0] != 2'b00);

  assign instr_in = instr_in_range ? mem[instr_idx] : '0;

  logic beat;
  logic core_wr_ok;
  logic instr_chk;

  assign beat       = (state == LOADING) && ld_valid && ld_ready;
  assign core_wr_ok = !data_rd_wr && !data_bad && (state != LOADING);
  // Fetch pointer is only meaningful once a program image has been loaded.
  assign instr_chk  = loaded_once && (state != LOADING);

  // Single RAM write port shared by loader and core. The two sources are
  // mutually exclusive by FSM state, so the loader always wins.
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = ld_ptr;
    mem_wdata = ld_data;
    if (!reset) begin
      if (beat) begin
        mem_we = 1'b1;
      end else if (core_wr_ok) begin
        mem_we    = 1'b1;
        mem_widx  = data_idx;
        mem_wdata = data_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ld_ptr      <= '0;
      ld_ready    <= 1'b0;
      ld_done     <= 1'b0;
      loaded_once <= 1'b0;
      data_in     <= '0;
      err_addr    <= 1'b0;
    end else begin
      // Data port: write-first on a successful store, zero on a dropped one.
      if (data_rd_wr) begin
        data_in <= data_in_range ? mem[data_idx] : '0;
      end else if (core_wr_ok) begin
        data_in <= data_out;
      end else begin
        data_in <= '0;
      end

      if (((state != LOADING) && data_bad) || (instr_chk && instr_bad)) begin
        err_addr <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (ld_start) begin
            state    <= LOADING;
            ld_ptr   <= '0;
            ld_done  <= 1'b0;
            ld_ready <= 1'b1;
          end
        end
        LOADING: begin
          // A restart still lets this cycle's beat land at the old pointer.
          if (ld_start) begin
            ld_ptr <= '0;
          end else if (beat) begin
            if (ld_last || (ld_ptr == LAST_IDX)) begin
              state       <= DONE;
              ld_ready    <= 1'b0;
              ld_done     <= 1'b1;
              loaded_once <= 1'b1;
            end else begin
              ld_ptr <= ld_ptr + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
